// File: rtl/mfp_adc_max10_sequencer_if.sv
// Avalon-ST command/response channel pair between the sequencer and the MAX10 modular ADC.
interface mfp_adc_max10_sequencer_if;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;

  modport master (
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );

  modport slave (
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );
endinterface

// File: rtl/mfp_adc_max10_sequencer.sv
// Sweeps enabled ADC slots in ascending order, one command/response at a time,
// and keeps the latest 12-bit sample of each slot in a readable result bank.
module mfp_adc_max10_sequencer #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned CH_BASE = 1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  mfp_adc_max10_sequencer_if.master   adc,
  input  logic [N_CH-1:0]             ch_enable,
  input  logic                        continuous,
  input  logic                        start,
  input  logic [$clog2(N_CH)-1:0]     rd_slot,
  output logic [11:0]                 rd_data,
  output logic [N_CH-1:0]             res_fresh,
  input  logic [N_CH-1:0]             fresh_clr,
  output logic                        busy,
  output logic                        sweep_done,
  output logic                        err_timeout,
  output logic                        err_channel
);

  localparam int unsigned SW = $clog2(N_CH);
  localparam int unsigned PW = SW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CMD,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [N_CH-1:0]        mask_q, mask_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [SW-1:0]          cur_q, cur_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic                   valid_q, valid_d;
  logic [4:0]             chan_q, chan_d;
  logic [N_CH-1:0][11:0]  res_q, res_d;
  logic [N_CH-1:0]        fresh_q, fresh_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_t_q, err_t_d;
  logic                   err_c_q, err_c_d;

  logic                   found_c;
  logic [SW-1:0]          pick_c;

  // Lowest enabled slot at or above the pointer; descending scan so the lowest wins.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (PW'(i) >= ptr_q)) begin
        found_c = 1'b1;
        pick_c  = SW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    res_d   = res_q;
    fresh_d = fresh_q & ~fresh_clr;
    err_t_d = err_t_q;
    err_c_d = err_c_q;

    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          mask_d  = ch_enable;
          ptr_d   = '0;
          state_d = (ch_enable == '0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        if (found_c) begin
          cur_d   = pick_c;
          chan_d  = 5'(CH_BASE) + 5'(pick_c);
          valid_d = 1'b1;
          state_d = S_CMD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CMD: begin
        if (adc.ADC_C_Ready) begin
          valid_d = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // chan_q still holds the commanded channel, so it doubles as the expected response tag.
        if (adc.ADC_R_Valid && (adc.ADC_R_Channel == chan_q)) begin
          res_d[cur_q]   = adc.ADC_R_Data;
          fresh_d[cur_q] = 1'b1;
          ptr_d          = PW'(cur_q) + PW'(1);
          state_d        = S_SELECT;
        end else begin
          if (adc.ADC_R_Valid) begin
            err_c_d = 1'b1;
          end
          if (tmo_q == CW'(TIMEOUT)) begin
            err_t_d = 1'b1;
            ptr_d   = PW'(cur_q) + PW'(1);
            state_d = S_SELECT;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        ptr_d = '0;
        if (continuous) begin
          mask_d  = ch_enable;
          state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      res_q   <= '0;
      fresh_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_t_q <= 1'b0;
      err_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      res_q   <= res_d;
      fresh_q <= fresh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_t_q <= err_t_d;
      err_c_q <= err_c_d;
    end
  end

  assign adc.ADC_C_Valid   = valid_q;
  assign adc.ADC_C_SOP     = valid_q;
  assign adc.ADC_C_EOP     = valid_q;
  assign adc.ADC_C_Channel = chan_q;

  assign rd_data     = res_q[rd_slot];
  assign res_fresh   = fresh_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign err_timeout = err_t_q;
  assign err_channel = err_c_q;

endmodule
